// File: rtl/serpent_pkg.sv
// Shared widths, rotate/shift amounts and rotate helpers for the Serpent linear transform.
package serpent_pkg;
  localparam int unsigned BLK_W  = 128;
  localparam int unsigned WORD_W = 32;

  localparam int unsigned ROT_A = 13;
  localparam int unsigned ROT_B = 3;
  localparam int unsigned ROT_C = 1;
  localparam int unsigned ROT_D = 7;
  localparam int unsigned ROT_E = 5;
  localparam int unsigned ROT_F = 22;
  localparam int unsigned SHF_A = 3;
  localparam int unsigned SHF_B = 7;

  localparam logic [5:0] BYPASS_ROUND_DFLT = 6'd31;

  typedef logic [WORD_W-1:0] word_t;

  function automatic word_t rol(input word_t x, input int unsigned n);
    return (x << n) | (x >> (WORD_W - n));
  endfunction

  function automatic word_t ror(input word_t x, input int unsigned n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction
endpackage

// File: rtl/serpent_lt_half.sv
// One half of the Serpent linear transform (forward or inverse), purely combinational.
module serpent_lt_half
  import serpent_pkg::*;
(
  input  logic [BLK_W-1:0] blk_i,
  input  logic             decrypt_i,
  input  logic             second_i,
  output logic [BLK_W-1:0] blk_o
);
  word_t x0, x1, x2, x3;

  always_comb begin
    x0 = blk_i[127:96];
    x1 = blk_i[95:64];
    x2 = blk_i[63:32];
    x3 = blk_i[31:0];
    if (!decrypt_i) begin
      if (!second_i) begin
        x0 = rol(x0, ROT_A);
        x2 = rol(x2, ROT_B);
        x1 = x1 ^ x0 ^ x2;
        x3 = x3 ^ x2 ^ (x0 << SHF_A);
        x1 = rol(x1, ROT_C);
        x3 = rol(x3, ROT_D);
      end else begin
        x0 = x0 ^ x1 ^ x3;
        x2 = x2 ^ x3 ^ (x1 << SHF_B);
        x0 = rol(x0, ROT_E);
        x2 = rol(x2, ROT_F);
      end
    end else begin
      // Inverse halves undo the forward halves in reverse order.
      if (!second_i) begin
        x2 = ror(x2, ROT_F);
        x0 = ror(x0, ROT_E);
        x2 = x2 ^ x3 ^ (x1 << SHF_B);
        x0 = x0 ^ x1 ^ x3;
        x3 = ror(x3, ROT_D);
        x1 = ror(x1, ROT_C);
      end else begin
        x3 = x3 ^ x2 ^ (x0 << SHF_A);
        x1 = x1 ^ x0 ^ x2;
        x2 = ror(x2, ROT_B);
        x0 = ror(x0, ROT_A);
      end
    end
    blk_o = {x0, x1, x2, x3};
  end
endmodule

// File: rtl/serpent_lt_pipe.sv
// Pipelined Serpent linear transform (forward/inverse, per-beat bypass) with valid/ready flow.
// Latency STAGES cycles; o_ready is combinational from i_ready so a full pipe can shift.
module serpent_lt_pipe
  import serpent_pkg::*;
#(
  parameter int unsigned STAGES       = 2,
  parameter int unsigned TAG_W        = 4,
  parameter logic [5:0]  BYPASS_ROUND = BYPASS_ROUND_DFLT
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [BLK_W-1:0] i_data,
  input  logic [5:0]       i_round,
  input  logic             i_decrypt,
  input  logic [TAG_W-1:0] i_tag,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [BLK_W-1:0] o_data,
  output logic [TAG_W-1:0] o_tag,
  output logic             o_busy
);
  logic             byp_in;
  logic [BLK_W-1:0] h0_out, h1_in, h1_out;
  logic             h1_dec;

  assign byp_in = (i_round == BYPASS_ROUND);

  serpent_lt_half u_half0 (
    .blk_i     (i_data),
    .decrypt_i (i_decrypt),
    .second_i  (1'b0),
    .blk_o     (h0_out)
  );

  serpent_lt_half u_half1 (
    .blk_i     (h1_in),
    .decrypt_i (h1_dec),
    .second_i  (1'b1),
    .blk_o     (h1_out)
  );

  if (STAGES == 1) begin : g_one
    logic             s_vld_q;
    logic [BLK_W-1:0] s_dat_q, s_dat_d;
    logic [TAG_W-1:0] s_tag_q;
    logic             s_en;

    assign h1_in   = h0_out;
    assign h1_dec  = i_decrypt;
    assign s_dat_d = byp_in ? i_data : h1_out;
    assign s_en    = ~s_vld_q | i_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        s_vld_q <= 1'b0;
        s_dat_q <= '0;
        s_tag_q <= '0;
      end else if (s_en) begin
        s_vld_q <= i_valid;
        if (i_valid) begin
          s_dat_q <= s_dat_d;
          s_tag_q <= i_tag;
        end
      end
    end

    assign o_ready = s_en;
    assign o_valid = s_vld_q;
    assign o_data  = s_dat_q;
    assign o_tag   = s_tag_q;
    assign o_busy  = s_vld_q;
  end else begin : g_two
    logic             a_vld_q, a_dec_q, a_byp_q, b_vld_q;
    logic [BLK_W-1:0] a_dat_q, a_dat_d, b_dat_q, b_dat_d;
    logic [TAG_W-1:0] a_tag_q, b_tag_q;
    logic             a_en, b_en;

    // A stage loads when empty or when its beat moves into B this cycle.
    assign b_en    = ~b_vld_q | i_ready;
    assign a_en    = ~a_vld_q | b_en;
    assign h1_in   = a_dat_q;
    assign h1_dec  = a_dec_q;
    assign a_dat_d = byp_in ? i_data : h0_out;
    assign b_dat_d = a_byp_q ? a_dat_q : h1_out;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        a_vld_q <= 1'b0;
        a_dec_q <= 1'b0;
        a_byp_q <= 1'b0;
        a_dat_q <= '0;
        a_tag_q <= '0;
        b_vld_q <= 1'b0;
        b_dat_q <= '0;
        b_tag_q <= '0;
      end else begin
        if (a_en) begin
          a_vld_q <= i_valid;
          if (i_valid) begin
            a_dat_q <= a_dat_d;
            a_tag_q <= i_tag;
            a_dec_q <= i_decrypt;
            a_byp_q <= byp_in;
          end
        end
        if (b_en) begin
          b_vld_q <= a_vld_q;
          if (a_vld_q) begin
            b_dat_q <= b_dat_d;
            b_tag_q <= a_tag_q;
          end
        end
      end
    end

    assign o_ready = a_en;
    assign o_valid = b_vld_q;
    assign o_data  = b_dat_q;
    assign o_tag   = b_tag_q;
    assign o_busy  = a_vld_q | b_vld_q;
  end
endmodule

// File: tb/tb_serpent_lt_pipe.sv
// Scoreboard bench: a two-stage and a one-stage instance, directed vectors plus round trip.
module tb_serpent_lt_pipe;
  typedef struct {
    int           dut;
    logic [3:0]   tag;
    logic [127:0] dat;
    bit           chk;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         in_vld  [2];
  logic         rdy     [2];
  logic [127:0] in_dat  [2];
  logic [5:0]   in_rnd  [2];
  logic         in_dec  [2];
  logic [3:0]   in_tag  [2];
  logic         out_vld [2];
  logic         out_rdy [2];
  logic [127:0] out_dat [2];
  logic [3:0]   out_tag [2];
  logic         busy    [2];

  int total = 0;
  int bad   = 0;

  exp_t         q[$];
  logic [127:0] cap[$];
  logic [127:0] orig [1000];
  logic [127:0] vin  [4];
  logic [127:0] vout [4];

  serpent_lt_pipe #(.STAGES(2), .TAG_W(4), .BYPASS_ROUND(6'd31)) u_dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(in_vld[0]), .o_ready(rdy[0]),
    .i_data(in_dat[0]), .i_round(in_rnd[0]), .i_decrypt(in_dec[0]), .i_tag(in_tag[0]),
    .o_valid(out_vld[0]), .i_ready(out_rdy[0]), .o_data(out_dat[0]), .o_tag(out_tag[0]),
    .o_busy(busy[0])
  );

  serpent_lt_pipe #(.STAGES(1), .TAG_W(4), .BYPASS_ROUND(6'd31)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(in_vld[1]), .o_ready(rdy[1]),
    .i_data(in_dat[1]), .i_round(in_rnd[1]), .i_decrypt(in_dec[1]), .i_tag(in_tag[1]),
    .o_valid(out_vld[1]), .i_ready(out_rdy[1]), .o_data(out_dat[1]), .o_tag(out_tag[1]),
    .o_busy(busy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    total++;
    bad++;
    $display("FAIL %s: timed out waiting for the DUT", nm);
  endtask

  // Issue one beat to instance d; the expected response is queued as the beat is offered.
  task automatic send(input int d, input logic [127:0] dat, input logic [5:0] rnd,
                      input logic dec, input logic [3:0] tag, input logic [127:0] expd,
                      input bit do_chk);
    exp_t e;
    int   n = 0;
    in_vld[d] = 1'b1;
    in_dat[d] = dat;
    in_rnd[d] = rnd;
    in_dec[d] = dec;
    in_tag[d] = tag;
    @(negedge clk);
    while (!rdy[d] && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!rdy[d]) timeout("send_ready");
    e.dut = d;
    e.tag = tag;
    e.dat = expd;
    e.chk = do_chk;
    q.push_back(e);
    @(posedge clk);
    #1;
    in_vld[d] = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    out_rdy[0] = 1'b1;
    out_rdy[1] = 1'b1;
    while (q.size() != 0 && n < 5000) begin
      @(posedge clk);
      n++;
    end
    chk("drain_pending", 128'(q.size()), 128'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic lat_beat(input int d, input int exp_lat, input logic [127:0] dat,
                          input logic [127:0] expd, input logic [3:0] tag);
    int lat = 1;
    send(d, dat, 6'd0, 1'b0, tag, expd, 1'b1);
    while (!out_vld[d] && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", 128'(lat), 128'(exp_lat));
  endtask

  // Monitor: pops expectations on each output transfer and checks stall stability.
  logic [127:0] pdat   [2];
  logic [3:0]   ptag   [2];
  bit           pstall [2];

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      pstall[0] = 1'b0;
      pstall[1] = 1'b0;
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (pstall[d]) begin
          chk("stall_valid", 128'(out_vld[d]), 128'd1);
          chk("stall_data", out_dat[d], pdat[d]);
          chk("stall_tag", 128'(out_tag[d]), 128'(ptag[d]));
        end
        pstall[d] = out_vld[d] && !out_rdy[d];
        pdat[d]   = out_dat[d];
        ptag[d]   = out_tag[d];
        if (out_vld[d] && out_rdy[d]) begin
          if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL spurious_output: dut %0d gave tag %h data %h, want no output", d, out_tag[d], out_dat[d]);
          end else begin
            e = q.pop_front();
            chk("dut_id", 128'(d), 128'(e.dut));
            chk("tag", 128'(out_tag[d]), 128'(e.tag));
            if (e.chk) chk("data", out_dat[d], e.dat);
            else cap.push_back(out_dat[d]);
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] r;
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      in_vld[d] = 1'b0; in_dat[d] = '0; in_rnd[d] = '0;
      in_dec[d] = 1'b0; in_tag[d] = '0; out_rdy[d] = 1'b1;
    end
    vin[0]  = 128'h00000001_00000000_00000000_00000000;
    vout[0] = 128'h100C0000_00004000_00002800_00800000;
    vin[1]  = 128'h00000000_00000000_00000000_00000001;
    vout[1] = 128'h00001000_00000000_20000000_00000080;
    vin[2]  = 128'h00000000_00000001_00000000_00000000;
    vout[2] = 128'h00000040_00000002_40000000_00000000;
    vin[3]  = 128'h00000000_00000000_00000001_00000000;
    vout[3] = 128'h00008200_00000010_02000003_00000400;

    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("reset_valid", 128'(out_vld[d]), 128'd0);
      chk("reset_busy", 128'(busy[d]), 128'd0);
      chk("reset_data", out_dat[d], 128'd0);
      chk("reset_tag", 128'(out_tag[d]), 128'd0);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 2; d++) chk("ready_after_reset", 128'(rdy[d]), 128'd1);
    @(posedge clk);
    #1;

    // Two-stage: latency, back-to-back alternating modes, bypass.
    lat_beat(0, 2, vin[0], vout[0], 4'h1);
    drain();
    for (int i = 0; i < 4; i++) begin
      send(0, vin[i], 6'd0, 1'b0, 4'(i), vout[i], 1'b1);
      send(0, vout[i], 6'd30, 1'b1, 4'(i + 8), vin[i], 1'b1);
    end
    for (int i = 0; i < 4; i++) begin
      r = {$urandom, $urandom, $urandom, $urandom};
      send(0, r, 6'd31, i[0], 4'(i + 4), r, 1'b1);
    end
    drain();

    // Backpressure: two beats fill the pipe, then random downstream readiness.
    out_rdy[0] = 1'b0;
    send(0, {4{32'h9E3779B9}}, 6'd31, 1'b0, 4'd0, {4{32'h9E3779B9}}, 1'b1);
    chk("ready_one_held", 128'(rdy[0]), 128'd1);
    send(0, {4{32'h3C6EF372}}, 6'd31, 1'b1, 4'd1, {4{32'h3C6EF372}}, 1'b1);
    chk("ready_two_held", 128'(rdy[0]), 128'd0);
    chk("busy_two_held", 128'(busy[0]), 128'd1);
    repeat (4) @(posedge clk);
    #1;
    fork
      begin
        for (int k = 2; k < 8; k++)
          send(0, {4{32'h9E3779B9 * 32'(k)}}, 6'd31, k[0], 4'(k), {4{32'h9E3779B9 * 32'(k)}}, 1'b1);
      end
      begin
        repeat (30) begin
          @(posedge clk);
          #1 out_rdy[0] = 1'($urandom_range(0, 1));
        end
        out_rdy[0] = 1'b1;
      end
    join
    drain();

    // Round trip: forward results are captured, then sent back through inverse.
    for (int i = 0; i < 1000; i++) begin
      orig[i] = {$urandom, $urandom, $urandom, $urandom};
      send(0, orig[i], 6'($urandom_range(0, 30)), 1'b0, 4'(i), 128'd0, 1'b0);
    end
    drain();
    chk("roundtrip_count", 128'(cap.size()), 128'd1000);
    for (int i = 0; i < 1000 && i < cap.size(); i++)
      send(0, cap[i], 6'($urandom_range(0, 30)), 1'b1, 4'(i), orig[i], 1'b1);
    drain();

    // Reset with two beats in flight.
    out_rdy[0] = 1'b0;
    send(0, vin[2], 6'd0, 1'b0, 4'hA, vout[2], 1'b1);
    send(0, vin[3], 6'd0, 1'b0, 4'hB, vout[3], 1'b1);
    rst_n = 1'b0;
    #1;
    chk("midreset_valid", 128'(out_vld[0]), 128'd0);
    chk("midreset_busy", 128'(busy[0]), 128'd0);
    q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("midreset_ready", 128'(rdy[0]), 128'd1);
    @(posedge clk);
    #1 out_rdy[0] = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    lat_beat(0, 2, vin[1], vout[1], 4'hC);
    drain();

    // One-stage instance: latency, inverse, occupancy limit.
    lat_beat(1, 1, vin[0], vout[0], 4'h3);
    drain();
    send(1, vout[2], 6'd5, 1'b1, 4'h5, vin[2], 1'b1);
    drain();
    out_rdy[1] = 1'b0;
    send(1, vin[3], 6'd1, 1'b0, 4'h6, vout[3], 1'b1);
    chk("s1_ready_full", 128'(rdy[1]), 128'd0);
    chk("s1_busy_full", 128'(busy[1]), 128'd1);
    repeat (3) @(posedge clk);
    #1;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
